press_counter: RTL and testbench
================================

PRESS_COUNTER -- requirements
Module: press_counter

Interface
REQ-001 Parameter SW_WIDTH, default 10: width of the switch input and the LED output.
REQ-002 Parameter CNT_DIGITS, default 2, range 1..8: number of hex digits in the counter, giving a counter width of 4*CNT_DIGITS bits.
REQ-003 Parameter SYNC_STAGES, default 2, minimum 2: number of synchroniser flops on key_i.
REQ-004 Parameter DEBOUNCE_CYC, default 4, minimum 1: number of consecutive stable synchronised samples needed to accept a key level change.
REQ-005 Parameter SATURATE, default 0: 0 means the counter wraps, 1 means it holds at its maximum.
REQ-006 clk100_i  in  1  100 MHz system clock; the block has this one clock only.
REQ-007 rst_i  in  1  reset, asynchronous, active-high.
REQ-008 sw_i  in  SW_WIDTH  data value captured on each accepted press.
REQ-009 key_i  in  1  raw push-button, active-high, asynchronous to clk100_i.
REQ-010 clr_i  in  1  synchronous clear of the counter and the overflow flag.
REQ-011 ledr_o  out  SW_WIDTH  value of sw_i captured at the last accepted press.
REQ-012 cnt_o  out  4*CNT_DIGITS  binary count of accepted presses.
REQ-013 hex_o  out  7*CNT_DIGITS  7-segment digits; digit k occupies bits [7k+6:7k] and shows nibble k of cnt_o.
REQ-014 ovf_o  out  1  sticky overflow/saturation flag.

Function
REQ-015 key_i SHALL pass through SYNC_STAGES flops before any other logic uses it; no other logic SHALL sample the raw key_i.
REQ-016 Debounce FSM states SHALL be RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-017 FSM transitions:
- RELEASED to PRESS_WAIT when sync key = 1.
- PRESS_WAIT to RELEASED when sync key = 0 before DEBOUNCE_CYC stable samples.
- PRESS_WAIT to PRESSED on the DEBOUNCE_CYC-th consecutive sample of 1.
- PRESSED and RELEASE_WAIT are symmetric for the 0 level.
REQ-018 The PRESS_WAIT-to-PRESSED transition SHALL be the sole "accept" event, and it SHALL update ledr_o and cnt_o on that same clock edge.
REQ-019 Latency from the first rising edge that samples key_i = 1 (key held stable) to updated outputs SHALL be exactly SYNC_STAGES + DEBOUNCE_CYC edges.
REQ-020 Glitches shorter than DEBOUNCE_CYC synchronised cycles SHALL cause no output change, in either direction.
REQ-021 A held key SHALL be accepted once only; the next accept SHALL require a debounced release first.
REQ-022 On accept, ledr_o SHALL take the synchronously sampled sw_i, and cnt_o SHALL increment by 1 modulo 2^(4*CNT_DIGITS).
REQ-023 Increment when cnt_o is at its maximum:
- SATURATE = 0: cnt_o wraps to 0 and ovf_o is set.
- SATURATE = 1: cnt_o holds at the maximum and ovf_o is set.
REQ-024 ovf_o SHALL stay set until clr_i or reset.
REQ-025 clr_i = 1 SHALL zero cnt_o and ovf_o on the next edge; ledr_o SHALL hold its value and the FSM SHALL be unaffected.
REQ-026 clr_i and accept on the same edge: clear SHALL win, and that accept SHALL be discarded with no increment and no ledr_o update.
REQ-027 hex_o SHALL be active-low with segment order {g,f,e,d,c,b,a} and registered, so it lags cnt_o by exactly 1 cycle.
REQ-028 hex_o digit codes:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
- 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

Reset
REQ-029 While rst_i = 1, regardless of the clock:
- ledr_o = 0, cnt_o = 0, ovf_o = 0.
- every hex_o digit = 1000000.
- FSM = RELEASED, synchroniser and debounce counter = 0.
REQ-030 If reset is asserted during PRESS_WAIT or PRESSED, the press SHALL be lost; after release the key SHALL need to be seen as 1 again, through the full latency, to be accepted.
REQ-031 Deassertion of rst_i SHALL take effect at the next clk100_i edge, with no spurious accept.

Verification
REQ-032 Defaults; sw_i = 10'h2A5; key_i high for 20 cycles -> after 6 edges ledr_o = 10'h2A5 and cnt_o = 8'h01; one cycle later hex_o[6:0] = 1111001 and hex_o[13:7] = 1000000.
REQ-033 key_i high for 2 cycles, then 20 cycles low -> ledr_o, cnt_o and hex_o unchanged.
REQ-034 key_i held high for 100 cycles with sw_i changing randomly -> cnt_o increments once only, and ledr_o keeps the value sampled at the accept edge.
REQ-035 Count overflow:
- SATURATE = 0, 256 clean presses -> cnt_o = 8'h00, ovf_o = 1.
- SATURATE = 1, same stimulus -> cnt_o = 8'hFF, ovf_o = 1.
- clr_i pulse afterwards -> cnt_o = 0, ovf_o = 0.
REQ-036 clr_i asserted on the accept edge, with cnt_o = 8'h05 -> cnt_o = 0, ledr_o unchanged.
REQ-037 rst_i pulse of 3 ns mid-PRESS_WAIT, not aligned to any clock edge -> all outputs reset immediately; the still-held key is accepted 6 edges after reset release, giving cnt_o = 1.

Source files
------------

// File: rtl/press_counter_if.sv
// Switch/key/clear inputs and LED/count/7-segment outputs of press_counter.
interface press_counter_if #(
  parameter int SW_WIDTH   = 10,
  parameter int CNT_DIGITS = 2
);
  logic [SW_WIDTH-1:0]     sw_i;
  logic                    key_i;
  logic                    clr_i;
  logic [SW_WIDTH-1:0]     ledr_o;
  logic [4*CNT_DIGITS-1:0] cnt_o;
  logic [7*CNT_DIGITS-1:0] hex_o;
  logic                    ovf_o;

  modport slave (
    input  sw_i, key_i, clr_i,
    output ledr_o, cnt_o, hex_o, ovf_o
  );

  modport master (
    output sw_i, key_i, clr_i,
    input  ledr_o, cnt_o, hex_o, ovf_o
  );
endinterface

// File: rtl/press_counter.sv
// Debounced push-button press counter: synchronises and debounces key_i, counts
// accepted presses, latches sw_i on each press and drives active-low 7-segment digits.
module press_counter #(
  parameter int SW_WIDTH     = 10,
  parameter int CNT_DIGITS   = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 4,
  parameter int SATURATE     = 0
) (
  input logic             clk100_i,
  input logic             rst_i,
  press_counter_if.slave  bus
);

  localparam int CW  = 4 * CNT_DIGITS;
  localparam int HW  = 7 * CNT_DIGITS;
  localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [DBW-1:0]          db_q, db_d;
  logic [SW_WIDTH-1:0]     ledr_q, ledr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [HW-1:0]           hex_q, hex_d;
  logic                    ovf_q, ovf_d;
  logic                    key_s;
  logic                    accept;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.key_i};
  assign key_s  = sync_q[SYNC_STAGES-1];

  // The edge leaving RELEASED/PRESSED already counts as the first stable sample.
  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    accept  = 1'b0;
    case (state_q)
      RELEASED: begin
        if (key_s) begin
          if (DEBOUNCE_CYC == 1) begin
            state_d = PRESSED;
            accept  = 1'b1;
          end else begin
            state_d = PRESS_WAIT;
            db_d    = DBW'(1);
          end
        end
      end
      PRESS_WAIT: begin
        if (!key_s) begin
          state_d = RELEASED;
          db_d    = '0;
        end else if (db_q == DB_LAST) begin
          state_d = PRESSED;
          db_d    = '0;
          accept  = 1'b1;
        end else begin
          db_d = db_q + DBW'(1);
        end
      end
      PRESSED: begin
        if (!key_s) begin
          if (DEBOUNCE_CYC == 1) begin
            state_d = RELEASED;
          end else begin
            state_d = RELEASE_WAIT;
            db_d    = DBW'(1);
          end
        end
      end
      default: begin
        if (key_s) begin
          state_d = PRESSED;
          db_d    = '0;
        end else if (db_q == DB_LAST) begin
          state_d = RELEASED;
          db_d    = '0;
        end else begin
          db_d = db_q + DBW'(1);
        end
      end
    endcase
  end

  // Clear takes priority over a coincident accept, which is then dropped entirely.
  always_comb begin
    ledr_d = ledr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (bus.clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (accept) begin
      ledr_d = bus.sw_i;
      if (cnt_q == '1) begin
        ovf_d = 1'b1;
        cnt_d = (SATURATE != 0) ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    hex_d = '1;
    for (int unsigned k = 0; k < CNT_DIGITS; k++) begin
      hex_d[7*k +: 7] = seg7(cnt_q[4*k +: 4]);
    end
  end

  always_ff @(posedge clk100_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RELEASED;
      sync_q  <= '0;
      db_q    <= '0;
      ledr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      hex_q   <= {CNT_DIGITS{7'b1000000}};
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      db_q    <= db_d;
      ledr_q  <= ledr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      hex_q   <= hex_d;
    end
  end

  assign bus.ledr_o = ledr_q;
  assign bus.cnt_o  = cnt_q;
  assign bus.hex_o  = hex_q;
  assign bus.ovf_o  = ovf_q;

endmodule

// File: tb/tb_press_counter.sv
// Directed bench for press_counter: wrapping DUT plus a saturating twin on shared inputs.
module tb_press_counter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  press_counter_if #(.SW_WIDTH(10), .CNT_DIGITS(2)) bw ();
  press_counter_if #(.SW_WIDTH(10), .CNT_DIGITS(2)) bs ();

  press_counter #(
    .SW_WIDTH(10), .CNT_DIGITS(2), .SYNC_STAGES(2), .DEBOUNCE_CYC(4), .SATURATE(0)
  ) dut_wrap (
    .clk100_i (clk),
    .rst_i    (rst),
    .bus      (bw)
  );

  press_counter #(
    .SW_WIDTH(10), .CNT_DIGITS(2), .SYNC_STAGES(2), .DEBOUNCE_CYC(4), .SATURATE(1)
  ) dut_sat (
    .clk100_i (clk),
    .rst_i    (rst),
    .bus      (bs)
  );

  assign bs.sw_i  = bw.sw_i;
  assign bs.key_i = bw.key_i;
  assign bs.clr_i = bw.clr_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    bw.key_i = 1'b1;
    repeat (8) tick();
    bw.key_i = 1'b0;
    repeat (8) tick();
  endtask

  logic [9:0] exp_led;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bw.sw_i  = '0;
    bw.key_i = 1'b0;
    bw.clr_i = 1'b0;

    // reset state, before any clock edge
    #2;
    check("rst_ledr", 32'(bw.ledr_o), 32'h0);
    check("rst_cnt",  32'(bw.cnt_o),  32'h0);
    check("rst_ovf",  32'(bw.ovf_o),  32'h0);
    check("rst_hex",  32'(bw.hex_o),  32'(14'b1000000_1000000));
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // clean press: exactly 6 edges of latency, hex one edge later
    bw.sw_i  = 10'h2A5;
    bw.key_i = 1'b1;
    repeat (5) tick();
    check("lat_cnt_early", 32'(bw.cnt_o), 32'h00);
    tick();
    check("lat_cnt",   32'(bw.cnt_o),  32'h01);
    check("lat_ledr",  32'(bw.ledr_o), 32'h2A5);
    check("hex_lag",   32'(bw.hex_o),  32'(14'b1000000_1000000));
    tick();
    check("hex_one",   32'(bw.hex_o),  32'(14'b1000000_1111001));
    repeat (13) tick();
    bw.key_i = 1'b0;
    repeat (10) tick();

    // 2-cycle glitch is rejected
    bw.sw_i  = 10'h0F0;
    bw.key_i = 1'b1;
    repeat (2) tick();
    bw.key_i = 1'b0;
    repeat (20) tick();
    check("glitch_cnt",  32'(bw.cnt_o),  32'h01);
    check("glitch_ledr", 32'(bw.ledr_o), 32'h2A5);
    check("glitch_hex",  32'(bw.hex_o),  32'(14'b1000000_1111001));

    // long hold with changing sw and a short release glitch: single accept
    exp_led = '0;
    bw.key_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bw.sw_i = 10'($urandom_range(0, 1023));
      if (i == 5) exp_led = bw.sw_i;
      if (i == 50 || i == 51) bw.key_i = 1'b0;
      else bw.key_i = 1'b1;
      tick();
    end
    bw.key_i = 1'b0;
    repeat (10) tick();
    check("hold_cnt",  32'(bw.cnt_o),  32'h02);
    check("hold_ledr", 32'(bw.ledr_o), 32'(exp_led));

    // clear on the accept edge wins
    bw.sw_i = 10'h155;
    repeat (3) press();
    check("five_cnt",  32'(bw.cnt_o),  32'h05);
    check("five_hex",  32'(bw.hex_o),  32'(14'b1000000_0010010));
    bw.sw_i  = 10'h3FF;
    bw.key_i = 1'b1;
    repeat (5) tick();
    bw.clr_i = 1'b1;
    tick();
    bw.clr_i = 1'b0;
    check("clr_acc_cnt",  32'(bw.cnt_o),  32'h00);
    check("clr_acc_ledr", 32'(bw.ledr_o), 32'h155);
    repeat (5) tick();
    check("clr_fsm_kept", 32'(bw.cnt_o),  32'h00);
    bw.key_i = 1'b0;
    repeat (8) tick();
    press();
    check("post_clr_cnt",  32'(bw.cnt_o),  32'h01);
    check("post_clr_ledr", 32'(bw.ledr_o), 32'h3FF);

    // overflow: wrap vs saturate, sticky flag, clear
    bw.clr_i = 1'b1;
    tick();
    bw.clr_i = 1'b0;
    check("ovf_start", 32'(bw.cnt_o), 32'h00);
    repeat (255) press();
    check("w255_cnt", 32'(bw.cnt_o), 32'hFF);
    check("w255_ovf", 32'(bw.ovf_o), 32'h0);
    check("s255_cnt", 32'(bs.cnt_o), 32'hFF);
    check("s255_ovf", 32'(bs.ovf_o), 32'h0);
    press();
    check("w256_cnt", 32'(bw.cnt_o), 32'h00);
    check("w256_ovf", 32'(bw.ovf_o), 32'h1);
    check("s256_cnt", 32'(bs.cnt_o), 32'hFF);
    check("s256_ovf", 32'(bs.ovf_o), 32'h1);
    press();
    check("w257_cnt", 32'(bw.cnt_o), 32'h01);
    check("w257_ovf", 32'(bw.ovf_o), 32'h1);
    check("s257_cnt", 32'(bs.cnt_o), 32'hFF);
    bw.clr_i = 1'b1;
    tick();
    bw.clr_i = 1'b0;
    check("wclr_cnt", 32'(bw.cnt_o), 32'h00);
    check("wclr_ovf", 32'(bw.ovf_o), 32'h0);
    check("sclr_cnt", 32'(bs.cnt_o), 32'h00);
    check("sclr_ovf", 32'(bs.ovf_o), 32'h0);

    // asynchronous reset pulse in PRESS_WAIT loses the press
    bw.sw_i = 10'h0C3;
    press();
    check("pre_rst_cnt", 32'(bw.cnt_o), 32'h01);
    bw.key_i = 1'b1;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_cnt",  32'(bw.cnt_o),  32'h00);
    check("arst_ledr", 32'(bw.ledr_o), 32'h000);
    check("arst_hex",  32'(bw.hex_o),  32'(14'b1000000_1000000));
    #2;
    rst = 1'b0;
    repeat (5) tick();
    check("rel_cnt_early", 32'(bw.cnt_o), 32'h00);
    tick();
    check("rel_cnt",  32'(bw.cnt_o),  32'h01);
    check("rel_ledr", 32'(bw.ledr_o), 32'h0C3);
    bw.key_i = 1'b0;
    repeat (8) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
